// File: rtl/poly_pointwise_mul_ctrl.sv
// Sequencer for one pointwise polynomial product: streams operand pairs into a
// fixed-latency modular multiplier and writes each product back at its index.
module poly_pointwise_mul_ctrl #(
  parameter int N     = 256,
  parameter int AW    = 8,
  parameter int WIDTH = 12,
  parameter int MOD   = 3329
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             range_err,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] a_rdata,
  input  logic [WIDTH-1:0] b_rdata,
  output logic             mul_en,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_r,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  localparam logic [AW:0]      LAST_RD  = (AW+1)'(N - 1);
  localparam logic [AW:0]      ALL_WR   = (AW+1)'(N);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [WIDTH-1:0] MOD_W    = WIDTH'(MOD);

  state_t      state, state_nxt;
  logic [AW:0] rd_cnt, wr_cnt;
  logic        rd_vld;
  logic        launch;
  logic        accept_res;

  assign launch     = (state == IDLE) && start;
  assign accept_res = mul_done && ((state == ISSUE) || (state == DRAIN));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // wr_cnt reaches N on the same edge that presents the write for index N-1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (rd_cnt == LAST_RD) state_nxt = DRAIN;
      DRAIN:   if (wr_en && (wr_cnt == ALL_WR)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = (state == FIN);
    rd_en   = (state == ISSUE);
    rd_addr = rd_cnt[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      rd_vld    <= 1'b0;
      range_err <= 1'b0;
      mul_en    <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      rd_vld <= rd_en;
      mul_en <= rd_vld;
      if (rd_vld) begin
        mul_a <= a_rdata;
        mul_b <= b_rdata;
      end

      if (launch) begin
        rd_cnt    <= '0;
        wr_cnt    <= '0;
        range_err <= 1'b0;
      end else begin
        if (rd_en) rd_cnt <= rd_cnt + CNT_ONE;
        if (rd_vld && ((a_rdata >= MOD_W) || (b_rdata >= MOD_W))) range_err <= 1'b1;
        if (accept_res) wr_cnt <= wr_cnt + CNT_ONE;
      end

      wr_en <= accept_res;
      if (accept_res) begin
        wr_addr <= wr_cnt[AW-1:0];
        wr_data <= mul_r;
      end
    end
  end

endmodule

// File: tb/tb_poly_pointwise_mul_ctrl.sv
// Directed bench for poly_pointwise_mul_ctrl with a behavioural source buffer
// and a fixed-latency (a*b mod q) multiplier model.
module tb_poly_pointwise_mul_ctrl;

  localparam int N = 256;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, range_err, rd_en, mul_en, mul_done, wr_en;
  logic [7:0]  rd_addr, wr_addr;
  logic [11:0] a_rdata, b_rdata, mul_a, mul_b, mul_r, wr_data;

  poly_pointwise_mul_ctrl #(.N(N), .AW(8), .WIDTH(12), .MOD(Q)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .range_err(range_err), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .mul_en(mul_en), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_r(mul_r), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  logic [11:0] a_mem [N];
  logic [11:0] b_mem [N];
  logic [11:0] exp_mem [N];

  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[rd_addr];
      b_rdata <= b_mem[rd_addr];
    end
  end

  // Multiplier: mul_done/mul_r appear 4 edges after the edge sampling mul_en.
  logic [4:0]  pv = '0;
  logic [11:0] pr [5];
  always @(posedge clk) begin
    pv    <= {pv[3:0], mul_en};
    pr[0] <= 12'((int'(mul_a) * int'(mul_b)) % Q);
    for (int i = 1; i < 5; i++) pr[i] <= pr[i-1];
  end
  assign mul_done = pv[4];
  assign mul_r    = pr[4];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int rd_seen, wr_seen, done_seen, done_cyc, e0;
  bit done_rerr, quiet;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rd_en) rd_seen++;
    if (wr_en) begin
      if (quiet) chk("write_after_reset", 1, 0);
      else begin
        chk("wr_addr_order", int'(wr_addr), wr_seen % N);
        chk("wr_data", int'(wr_data), int'(exp_mem[wr_addr]));
      end
      wr_seen++;
    end
    if (done) begin
      done_seen++;
      done_cyc  = cyc;
      done_rerr = range_err;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0    = cyc;
    start = 1'b0;
  endtask

  task automatic clear_counts();
    rd_seen = 0; wr_seen = 0; done_seen = 0; done_cyc = -1;
  endtask

  task automatic run_and_check(input bit extra_starts, input bit exp_rerr);
    clear_counts();
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    chk("range_err_cleared", int'(range_err), 0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start = extra_starts && ((cyc - e0 == 10) || (cyc - e0 == 264));
    end
    start = 1'b0;
    chk("done_count", done_seen, 1);
    chk("done_edge", done_cyc - e0, 264);
    chk("rd_count", rd_seen, N);
    chk("wr_count", wr_seen, N);
    chk("range_err_at_done", int'(done_rerr), int'(exp_rerr));
    chk("range_err_sticky", int'(range_err), int'(exp_rerr));
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      a_mem[i]   = 12'($urandom_range(Q - 1));
      b_mem[i]   = 12'($urandom_range(Q - 1));
      exp_mem[i] = 12'((int'(a_mem[i]) * int'(b_mem[i])) % Q);
    end
  endtask

  typedef struct {
    logic [11:0] a, b, exp;
  } fill_t;

  typedef struct {
    int unsigned idx;
    logic [11:0] a, b, exp;
  } mix_t;

  fill_t fills [2];
  mix_t  mixes [6];

  initial begin
    fills[0] = '{a: 12'd1,    b: 12'd1,    exp: 12'd1};
    fills[1] = '{a: 12'd3328, b: 12'd3328, exp: 12'd1};
    mixes[0] = '{idx: 0,   a: 12'd1000, b: 12'd2000, exp: 12'd2600};
    mixes[1] = '{idx: 1,   a: 12'd2,    b: 12'd1665, exp: 12'd1};
    mixes[2] = '{idx: 2,   a: 12'd0,    b: 12'd3328, exp: 12'd0};
    mixes[3] = '{idx: 3,   a: 12'd3328, b: 12'd2,    exp: 12'd3327};
    mixes[4] = '{idx: 4,   a: 12'd1664, b: 12'd2,    exp: 12'd3328};
    mixes[5] = '{idx: 255, a: 12'd3328, b: 12'd3327, exp: 12'd2};

    quiet = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_range_err", int'(range_err), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_mul_en", int'(mul_en), 0);
    chk("rst_mul_ab", int'({mul_a, mul_b}), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr_data", int'({wr_addr, wr_data}), 0);
    clear_counts();
    repeat (20) @(negedge clk);
    chk("idle_no_reads", rd_seen, 0);
    chk("idle_no_writes", wr_seen, 0);

    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < N; i++) begin
        a_mem[i]   = fills[t].a;
        b_mem[i]   = fills[t].b;
        exp_mem[i] = fills[t].exp;
      end
      run_and_check(1'b0, 1'b0);
    end

    fill_random();
    for (int t = 0; t < 6; t++) begin
      a_mem[mixes[t].idx]   = mixes[t].a;
      b_mem[mixes[t].idx]   = mixes[t].b;
      exp_mem[mixes[t].idx] = mixes[t].exp;
    end
    run_and_check(1'b0, 1'b0);

    fill_random();
    run_and_check(1'b1, 1'b0);

    // Abort at cycle 100; in-flight products must not be written afterwards.
    clear_counts();
    pulse_start();
    while (cyc - e0 < 99) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    quiet = 1'b1;
    chk("abort_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    rd_seen = 0;
    wr_seen = 0;
    repeat (30) @(negedge clk);
    chk("abort_no_reads", rd_seen, 0);
    chk("abort_no_writes", wr_seen, 0);
    chk("abort_no_done", done_seen, 0);
    quiet = 1'b0;
    fill_random();
    run_and_check(1'b0, 1'b0);

    fill_random();
    b_mem[37]   = 12'd3329;
    exp_mem[37] = 12'd0;
    run_and_check(1'b0, 1'b1);
    fill_random();
    run_and_check(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
